apu_dispatcher: RTL and testbench
=================================

# apu_dispatcher

Core-side initiator for the accelerator APU interface. It buffers vector instructions issued by the scalar pipeline and drives them one at a time onto the APU request channel (req/gnt). It waits for the single-cycle result strobe and returns the scalar result (e.g. vsetvli new VL, vmv.x.s) to the register-file writeback port. It is the counterpart of the accelerator's vector decoder, which accepts one instruction per grant and answers with exactly one `apu_rvalid` pulse.

## Interface
- `FIFO_DEPTH`, default 2: instruction buffer entries; power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `instr_valid_i`  in  1  pipeline offers a vector instruction.
- `instr_ready_o`  out  1  buffer not full; transfer on valid&ready.
- `instr_i`  in  32  raw instruction word.
- `rs1_i`, `rs2_i`  in  32 each  scalar operands.
- `op_i`  in  6  APU op code.
- `flags_i`  in  15  APU flags.
- `rd_i`  in  5  scalar destination register.
- `writes_rd_i`  in  1  instruction returns a scalar result.
- `apu_req`  out  1  request to accelerator.
- `apu_gnt`  in  1  accelerator accepts request.
- `apu_operands`  out  3×32  [0]=instr, [1]=rs1, [2]=rs2.
- `apu_op`  out  6  op code of FIFO head.
- `apu_flags_o`  out  15  flags of FIFO head.
- `apu_rvalid`  in  1  one-cycle result strobe; cannot be back-pressured.
- `apu_result`  in  32  result, valid with `apu_rvalid`.
- `wb_valid_o`  out  1  scalar writeback pending.
- `wb_ready_i`  in  1  register file accepts writeback.
- `wb_rd_o`  out  5  writeback register.
- `wb_data_o`  out  32  writeback data.
- `busy_o`  out  1  any instruction buffered, in flight or awaiting writeback.
- `protocol_err_o`  out  1  sticky: `apu_rvalid` seen outside RESP.

## Operation
- FIFO stores {instr, rs1, rs2, op, flags, rd, writes_rd}. It supports push and pop in the same cycle, including when full (pop frees the slot first, push accepted). `instr_ready_o = ~full`.
- `apu_operands`, `apu_op` and `apu_flags_o` are driven from the FIFO head at all times. They are stable throughout REQ because a pop occurs only on grant.
- FSM states:
  - IDLE: `apu_req=0`. Go to REQ when FIFO non-empty and `~wb_valid_o`.
  - REQ: `apu_req=1`. On `apu_gnt`, pop the head, latch its rd/writes_rd into in-flight registers, and go to RESP. Otherwise hold, with `apu_req` stable.
  - RESP: `apu_req=0`. On `apu_rvalid`:
    - if the latched writes_rd is set, load `wb_data_o<=apu_result`, `wb_rd_o<=rd` and `wb_valid_o<=1`;
    - otherwise discard the result;
    - go to IDLE.
- Only one instruction is outstanding. A new request is not started while a writeback is pending, so a result strobe never finds the result register occupied.
- `wb_valid_o` clears on `wb_valid_o & wb_ready_i`. `wb_rd_o`/`wb_data_o` hold while pending.
- `apu_rvalid` in IDLE or REQ is ignored and sets `protocol_err_o`, which clears only on reset.
- `busy_o = ~empty | (state!=IDLE) | wb_valid_o`.

## Timing
- Reset values:
  - state IDLE; FIFO empty.
  - `instr_ready_o=1`, `apu_req=0`, `wb_valid_o=0`, `wb_rd_o=0`, `wb_data_o=0`, `busy_o=0`, `protocol_err_o=0`.
  - `apu_operands`/`apu_op`/`apu_flags_o` = 0 (empty FIFO storage reset to 0).
- Instruction accepted in cycle N into an empty, idle dispatcher → FIFO non-empty at N+1 → `apu_req=1` at N+2.
- A grant in the first REQ cycle gives 1 REQ cycle; the request may wait any number of cycles for a grant.
- `apu_rvalid` at cycle M → `wb_valid_o=1` at M+1. State is IDLE at M+1, and with another entry and no writeback, `apu_req=1` at M+2.
- Writeback handshake at cycle K → `wb_valid_o=0` at K+1. The IDLE→REQ decision uses `wb_valid_o`, so `apu_req` goes high at K+2 at the earliest.
- Asserting `n_reset` mid-operation aborts everything immediately. The buffered instructions, the in-flight instruction and any pending writeback are lost. A late `apu_rvalid` after reset sets `protocol_err_o`.

## Test plan
- Single vsetvli (writes_rd=1, rd=5), gnt held high, rvalid 2 cycles after grant with result 0x10 → `apu_req` is high for exactly 1 cycle at N+2; `wb_valid_o` rises with rd=5, data=0x10; it clears after `wb_ready_i`.
- Gnt withheld for 4 cycles → `apu_req` and all operands are held constant for 5 cycles; the FIFO pops only on the grant cycle.
- Store instruction (writes_rd=0), rvalid result 0xDEAD → no `wb_valid_o`; `busy_o` drops the cycle after the strobe.
- Back-to-back fill: 3 instructions pushed with FIFO_DEPTH=2 → `instr_ready_o=0` after 2 pushes. The third is accepted in the grant/pop cycle of the first, and all three are issued in order with matching operands.
- vmv.x.s result pending while `wb_ready_i=0` for 6 cycles, with a second instruction queued → no `apu_req` until 2 cycles after the writeback handshake.
- rvalid pulsed in IDLE → `protocol_err_o=1`, sticky, with no writeback. Reset asserted in RESP → all outputs return to reset values on that edge.

Source files
------------

// File: rtl/apu_dispatcher.sv
// apu_dispatcher: buffers vector instructions and issues them one at a time on the APU req/gnt channel, returning scalar results to writeback
// Ports:
//   clk, n_reset                    clock, async active-low reset
//   instr_valid_i/instr_ready_o     pipeline push handshake with instr_i, rs1_i, rs2_i, op_i, flags_i, rd_i, writes_rd_i
//   apu_req/apu_gnt                 accelerator request channel; apu_operands/apu_op/apu_flags_o show the buffer head
//   apu_rvalid/apu_result           single-cycle result strobe from the accelerator
//   wb_valid_o/wb_ready_i           scalar writeback handshake with wb_rd_o, wb_data_o
//   busy_o, protocol_err_o          activity and sticky stray-strobe indication
module apu_dispatcher #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      rs1_i,
  input  logic [31:0]      rs2_i,
  input  logic [5:0]       op_i,
  input  logic [14:0]      flags_i,
  input  logic [4:0]       rd_i,
  input  logic             writes_rd_i,
  output logic             apu_req,
  input  logic             apu_gnt,
  output logic [2:0][31:0] apu_operands,
  output logic [5:0]       apu_op,
  output logic [14:0]      apu_flags_o,
  input  logic             apu_rvalid,
  input  logic [31:0]      apu_result,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [4:0]       wb_rd_o,
  output logic [31:0]      wb_data_o,
  output logic             busy_o,
  output logic             protocol_err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  op;
    logic [14:0] flags;
    logic [4:0]  rd;
    logic        wr;
  } entry_t;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, pop, push;
  state_t        state;
  logic          fl_wr;
  logic [4:0]    fl_rd;
  assign head          = mem[rptr];
  assign full          = count == (AW+1)'(FIFO_DEPTH);
  assign empty         = count == '0;
  assign pop           = state == REQ && apu_gnt;
  // a pop in the same cycle frees the head slot, so a push is taken even when full
  assign push          = instr_valid_i && (!full || pop);
  assign instr_ready_o = !full;
  assign apu_operands  = {head.rs2, head.rs1, head.instr};
  assign apu_op        = head.op;
  assign apu_flags_o   = head.flags;
  assign busy_o        = !empty || state != IDLE || wb_valid_o;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {instr_i, rs1_i, rs2_i, op_i, flags_i, rd_i, writes_rd_i};
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state          <= IDLE;
      apu_req        <= 1'b0;
      fl_wr          <= 1'b0;
      fl_rd          <= '0;
      wb_valid_o     <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (wb_valid_o && wb_ready_i) wb_valid_o <= 1'b0;
      if (apu_rvalid && state != RESP) protocol_err_o <= 1'b1;
      case (state)
        // holding off while a writeback is pending guarantees the result register is free on the next strobe
        IDLE: if (!empty && !wb_valid_o) begin
          state   <= REQ;
          apu_req <= 1'b1;
        end
        REQ: if (apu_gnt) begin
          state   <= RESP;
          apu_req <= 1'b0;
          fl_rd   <= head.rd;
          fl_wr   <= head.wr;
        end
        RESP: if (apu_rvalid) begin
          state <= IDLE;
          if (fl_wr) begin
            wb_valid_o <= 1'b1;
            wb_rd_o    <= fl_rd;
            wb_data_o  <= apu_result;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apu_dispatcher.sv
// tb_apu_dispatcher: directed table, hand-written corner sequences and a randomized scoreboard run for apu_dispatcher
module tb_apu_dispatcher;
  localparam int D = 2;
  typedef struct {
    logic [31:0] instr, rs1, rs2;
    logic [5:0]  op;
    logic [14:0] flags;
    logic [4:0]  rd;
    logic        wr;
  } ins_t;
  typedef struct {
    logic v, wr; logic [4:0] rd; logic gnt, rv; logic [31:0] res; logic wbr;
    logic e_req, e_wbv; logic [4:0] e_rd; logic [31:0] e_data; logic e_busy, e_rdy;
  } vec_t;
  logic clk = 0, n_reset = 0;
  logic v = 0, wr = 0, gnt = 0, rvalid = 0, wbr = 0;
  logic [31:0] instr = 0, rs1 = 0, rs2 = 0, result = 0;
  logic [5:0] op = 0;
  logic [14:0] flags = 0;
  logic [4:0] rd = 0;
  logic ready, req, wbv, busy, err;
  logic [2:0][31:0] ops;
  logic [5:0] aop;
  logic [14:0] aflags;
  logic [4:0] wrd;
  logic [31:0] wdata;
  int checks = 0, errors = 0;
  apu_dispatcher #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .n_reset(n_reset), .instr_valid_i(v), .instr_ready_o(ready),
    .instr_i(instr), .rs1_i(rs1), .rs2_i(rs2), .op_i(op), .flags_i(flags), .rd_i(rd), .writes_rd_i(wr),
    .apu_req(req), .apu_gnt(gnt), .apu_operands(ops), .apu_op(aop), .apu_flags_o(aflags),
    .apu_rvalid(rvalid), .apu_result(result), .wb_valid_o(wbv), .wb_ready_i(wbr),
    .wb_rd_o(wrd), .wb_data_o(wdata), .busy_o(busy), .protocol_err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic ins_t rnd_ins();
    ins_t e;
    e.instr = $urandom; e.rs1 = $urandom; e.rs2 = $urandom;
    e.op = 6'($urandom); e.flags = 15'($urandom); e.rd = 5'($urandom); e.wr = 1'($urandom);
    return e;
  endfunction
  task automatic drive(input ins_t e);
    instr = e.instr; rs1 = e.rs1; rs2 = e.rs2; op = e.op; flags = e.flags; rd = e.rd; wr = e.wr;
  endtask
  task automatic chk_head(input string nm, input ins_t e);
    chk({nm, "_instr"}, ops[0], e.instr);
    chk({nm, "_rs1"}, ops[1], e.rs1);
    chk({nm, "_rs2"}, ops[2], e.rs2);
    chk({nm, "_op"}, aop, e.op);
    chk({nm, "_flags"}, aflags, e.flags);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_req"}, req, 0); chk({nm, "_ready"}, ready, 1); chk({nm, "_wbv"}, wbv, 0);
    chk({nm, "_wbrd"}, wrd, 0); chk({nm, "_wbdata"}, wdata, 0); chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, 0); chk({nm, "_ops"}, ops, 0); chk({nm, "_op"}, aop, 0); chk({nm, "_flags"}, aflags, 0);
  endtask
  function automatic vec_t mk(logic v_, wr_, logic [4:0] rd_, logic g_, rv_, logic [31:0] res_, logic wbr_,
                              logic er, ew, logic [4:0] erd_, logic [31:0] ed, logic eb, ey);
    vec_t t;
    t.v = v_; t.wr = wr_; t.rd = rd_; t.gnt = g_; t.rv = rv_; t.res = res_; t.wbr = wbr_;
    t.e_req = er; t.e_wbv = ew; t.e_rd = erd_; t.e_data = ed; t.e_busy = eb; t.e_rdy = ey;
    return t;
  endfunction
  vec_t tbl [13];
  ins_t e0, e1, e2, fl;
  ins_t q[$];
  bit fl_act, ewb, prev_hold, popq, acc;
  int cd, stall;
  logic [4:0] erd;
  logic [31:0] edata;
  initial begin
    tbl[0]  = mk(1, 1, 5, 1, 0, 0,     0, 0, 0, 0, 0,     0, 1);
    tbl[1]  = mk(0, 0, 0, 1, 0, 0,     0, 0, 0, 0, 0,     1, 1);
    tbl[2]  = mk(0, 0, 0, 1, 0, 0,     0, 1, 0, 0, 0,     1, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 1);
    tbl[4]  = mk(0, 0, 0, 0, 1, 32'h10, 0, 0, 0, 0, 0,    1, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,     0, 0, 1, 5, 32'h10, 1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,     1, 0, 1, 5, 32'h10, 1, 1);
    tbl[7]  = mk(1, 0, 3, 1, 0, 0,     0, 0, 0, 5, 32'h10, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 0, 0,     0, 0, 0, 5, 32'h10, 1, 1);
    tbl[9]  = mk(0, 0, 0, 1, 0, 0,     0, 1, 0, 5, 32'h10, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, 1, 32'hDEAD, 0, 0, 0, 5, 32'h10, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 5, 32'h10, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,     0, 0, 0, 5, 32'h10, 0, 1);
    repeat (2) @(negedge clk);
    chk_reset("reset");
    n_reset = 1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk($sformatf("t%0d_req", i), req, tbl[i].e_req);
      chk($sformatf("t%0d_wbv", i), wbv, tbl[i].e_wbv);
      chk($sformatf("t%0d_wbrd", i), wrd, tbl[i].e_rd);
      chk($sformatf("t%0d_wbdata", i), wdata, tbl[i].e_data);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("t%0d_ready", i), ready, tbl[i].e_rdy);
      e0 = rnd_ins(); e0.wr = tbl[i].wr; e0.rd = tbl[i].rd; drive(e0);
      v = tbl[i].v; gnt = tbl[i].gnt; rvalid = tbl[i].rv; result = tbl[i].res; wbr = tbl[i].wbr;
    end
    // grant withheld for 4 cycles with a full buffer
    e0 = rnd_ins(); e0.wr = 0; e1 = rnd_ins(); e1.wr = 0;
    @(negedge clk); drive(e0); v = 1;
    @(negedge clk); drive(e1); v = 1;
    @(negedge clk); v = 0; gnt = 0;
    chk("hold_req0", req, 1); chk("hold_ready0", ready, 0); chk_head("hold0", e0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_req", req, 1); chk("hold_ready", ready, 0); chk_head("hold", e0);
      if (i == 3) gnt = 1;
    end
    @(negedge clk); gnt = 0; rvalid = 1;
    chk("hold_after_req", req, 0); chk("hold_after_ready", ready, 1); chk_head("hold_next", e1);
    @(negedge clk); rvalid = 0;
    @(negedge clk); chk("hold_e1_req", req, 1); chk_head("hold_e1", e1); gnt = 1;
    @(negedge clk); gnt = 0; rvalid = 1;
    @(negedge clk); rvalid = 0;
    @(negedge clk); chk("hold_busy", busy, 0);
    // back-to-back fill: third push lands in the pop cycle of the first
    e0 = rnd_ins(); e0.wr = 0; e1 = rnd_ins(); e1.wr = 0; e2 = rnd_ins(); e2.wr = 0;
    drive(e0); v = 1;
    @(negedge clk); chk("fill_ready1", ready, 1); drive(e1);
    @(negedge clk); chk("fill_ready2", ready, 0); chk("fill_req", req, 1); chk_head("fill0", e0); drive(e2); gnt = 1;
    @(negedge clk); v = 0; gnt = 0; rvalid = 1;
    chk("fill_ready3", ready, 0); chk("fill_req_off", req, 0); chk_head("fill_h1", e1);
    @(negedge clk); rvalid = 0;
    @(negedge clk); chk("fill_req1", req, 1); chk_head("fill1", e1); gnt = 1;
    @(negedge clk); gnt = 0; rvalid = 1; chk("fill_ready4", ready, 1);
    @(negedge clk); rvalid = 0;
    @(negedge clk); chk("fill_req2", req, 1); chk_head("fill2", e2); gnt = 1;
    @(negedge clk); gnt = 0; rvalid = 1;
    @(negedge clk); rvalid = 0;
    @(negedge clk); chk("fill_busy", busy, 0);
    // writeback stalled with a second instruction queued
    e0 = rnd_ins(); e0.wr = 1; e0.rd = 7; e1 = rnd_ins(); e1.wr = 0;
    drive(e0); v = 1;
    @(negedge clk); drive(e1);
    @(negedge clk); v = 0; chk("wb_req0", req, 1); chk_head("wb_h0", e0); gnt = 1;
    @(negedge clk); gnt = 0; rvalid = 1; result = 32'hCAFE1234;
    @(negedge clk); rvalid = 0; wbr = 0;
    chk("wb_valid", wbv, 1); chk("wb_rd", wrd, 7); chk("wb_data", wdata, 32'hCAFE1234); chk("wb_noreq", req, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wb_stall_valid", wbv, 1); chk("wb_stall_noreq", req, 0); chk("wb_stall_rd", wrd, 7);
      if (i == 5) wbr = 1;
    end
    @(negedge clk); wbr = 0; chk("wb_cleared", wbv, 0); chk("wb_k1_noreq", req, 0);
    @(negedge clk); chk("wb_k2_req", req, 1); chk_head("wb_h1", e1); gnt = 1;
    @(negedge clk); gnt = 0; rvalid = 1;
    @(negedge clk); rvalid = 0;
    @(negedge clk); chk("wb_busy", busy, 0);
    // stray strobe in IDLE, then reset while in RESP
    rvalid = 1;
    @(negedge clk); rvalid = 0; chk("err_set", err, 1); chk("err_nowb", wbv, 0);
    repeat (3) begin @(negedge clk); chk("err_sticky", err, 1); end
    e0 = rnd_ins(); e0.wr = 1; drive(e0); v = 1;
    @(negedge clk); v = 0;
    @(negedge clk); chk("rst_req", req, 1); gnt = 1;
    @(negedge clk); gnt = 0;
    #1 n_reset = 0;
    #1 chk_reset("midreset");
    @(negedge clk); n_reset = 1; rvalid = 1;
    @(negedge clk); rvalid = 0; chk("late_rvalid_err", err, 1); chk("late_rvalid_nowb", wbv, 0);
    n_reset = 0;
    @(negedge clk); n_reset = 1;
    // randomized run against a transaction-level scoreboard
    fl_act = 0; ewb = 0; prev_hold = 0; cd = 0; stall = 0; erd = 0; edata = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("r_ready", ready, q.size() < D);
      chk("r_wbv", wbv, ewb);
      chk("r_wbrd", wrd, erd);
      chk("r_wbdata", wdata, edata);
      chk("r_busy", busy, q.size() > 0 || fl_act || ewb);
      chk("r_err", err, 0);
      if (req) begin
        chk("r_req_allowed", q.size() > 0 && !fl_act && !ewb, 1);
        if (q.size() > 0) chk_head("r_head", q[0]);
      end
      if (prev_hold) chk("r_req_hold", req, 1);
      stall = (q.size() > 0 && !fl_act && !ewb && !req) ? stall + 1 : 0;
      chk("r_issue_latency", stall > 1, 0);
      gnt = 1'($urandom);
      wbr = 1'($urandom);
      rvalid = 0;
      if (fl_act) begin
        if (cd == 0) begin rvalid = 1; result = $urandom; end
        else cd--;
      end
      e0 = rnd_ins(); drive(e0); v = $urandom_range(0, 2) != 0;
      popq = req && gnt;
      if (ewb && wbr) ewb = 0;
      if (rvalid) begin
        fl_act = 0;
        if (fl.wr) begin ewb = 1; erd = fl.rd; edata = result; end
      end
      if (popq && q.size() > 0) begin fl = q.pop_front(); fl_act = 1; cd = $urandom_range(0, 3); end
      acc = v && q.size() < D;
      if (acc) q.push_back(e0);
      prev_hold = req && !gnt;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
